// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding and default width.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier_step_counter.sv
// Iteration counter for the multiplier; cout flags the last step of an operation.
module step_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          cout
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign cout  = &r_count;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: WIDTH add/shift steps per operation, start/busy/done handshake.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [CW-1:0]      step
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_p;
  logic               w_accept;
  logic               w_cout;
  logic [WIDTH:0]     w_sum;

  assign w_accept = (r_state == IDLE) && start;

  step_counter #(
    .CW (CW)
  ) u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (r_state == CALC),
    .clr   (w_accept),
    .count (step),
    .cout  (w_cout)
  );

  // Upper half plus multiplicand, kept WIDTH+1 wide so the carry shifts into the MSB.
  always_comb begin
    w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]};
    if (r_p[0]) begin
      w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_p     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_p     <= {{WIDTH{1'b0}}, b};
            r_state <= CALC;
          end
        end
        CALC: begin
          r_p <= {w_sum, r_p[WIDTH-1:1]};
          if (w_cout) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (r_state == CALC);
  assign done    = (r_state == DONE);
  assign product = r_p;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed scoreboard bench for seq_shift_add_multiplier (WIDTH = 16).
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [3:0]  step;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  int unsigned n_done = 0;
  logic [31:0] sb[$];
  int unsigned done_cyc[$];

  seq_shift_add_multiplier #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .step    (step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: pop the expected product on every done pulse.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("busy_done_exclusive", {63'b0, busy & done}, 64'd0);
      if (done === 1'b1) begin
        n_done++;
        done_cyc.push_back(cyc);
        check("step_wrapped_at_done", {60'b0, step}, 64'd0);
        if (sb.size() == 0) begin
          check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
          check("product_at_done", {32'b0, product}, {32'b0, sb.pop_front()});
        end
      end
    end
  end

  // spurious_at >= 0 pulses start (with other operands) during that busy cycle index.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input int spurious_at);
    int unsigned n;
    int unsigned bc;
    int unsigned d0;
    logic [31:0] e;
    @(negedge clk);
    e = {16'b0, ia} * {16'b0, ib};
    a = ia; b = ib; start = 1'b1;
    sb.push_back(e);
    d0 = n_done;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      if (n == 15) check("step_before_tc", {60'b0, step}, 64'd15);
      if (spurious_at >= 0 && n == spurious_at) begin
        start = 1'b1; a = 16'hBEEF; b = 16'h0011;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_latency", 64'(n), 64'd16);
    check("busy_cycles", 64'(bc), 64'd16);
    @(negedge clk);
    check("done_single_pulse", {63'b0, done}, 64'd0);
    check("product_held_idle", {32'b0, product}, {32'b0, e});
    check("done_count", 64'(n_done - d0), 64'd1);
    @(negedge clk);
    check("idle_after_op", {63'b0, busy}, 64'd0);
    check("product_held_idle2", {32'b0, product}, {32'b0, e});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; a = '0; b = '0;
    #23;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_product", {32'b0, product}, 64'd0);
    check("rst_step", {60'b0, step}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(16'd3, 16'd5, -1);
    run_op(16'hFFFF, 16'hFFFF, -1);
    run_op(16'h1234, 16'h0000, -1);
    run_op(16'h0000, 16'hABCD, -1);
    run_op(16'h00C3, 16'h0A05, 4);
    check("ignored_start_queue", 64'(sb.size()), 64'd0);

    // Abort mid-calculation with an asynchronous reset.
    @(negedge clk);
    a = 16'h0055; b = 16'h0066; start = 1'b1;
    sb.push_back(32'h0055 * 32'h0066);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_before_abort", {63'b0, busy}, 64'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_product", {32'b0, product}, 64'd0);
    check("abort_step", {60'b0, step}, 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    run_op(16'd7, 16'd9, -1);

    // Start held high: back-to-back operations.
    begin
      int unsigned n;
      int unsigned d0;
      int unsigned c0;
      @(negedge clk);
      a = 16'h0100; b = 16'h0100; start = 1'b1;
      repeat (3) sb.push_back(32'h0001_0000);
      d0 = n_done;
      c0 = done_cyc.size();
      n = 0;
      while (n_done - d0 < 3 && n < 100) begin
        @(negedge clk);
        n++;
      end
      start = 1'b0;
      check("held_done_count", 64'(n_done - d0), 64'd3);
      if (done_cyc.size() >= c0 + 3) begin
        check("held_period_1", 64'(done_cyc[c0+1] - done_cyc[c0]), 64'd18);
        check("held_period_2", 64'(done_cyc[c0+2] - done_cyc[c0+1]), 64'd18);
      end else begin
        check("held_done_recorded", 64'(done_cyc.size() - c0), 64'd3);
      end
      repeat (3) @(negedge clk);
      check("held_sb_drained", 64'(sb.size()), 64'd0);
      check("held_idle", {63'b0, busy}, 64'd0);
      check("held_product", {32'b0, product}, 64'h0001_0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
# seq_shift_add_multiplier

Iterative unsigned shift-add multiplier that uses a step counter to sequence exactly WIDTH add/shift iterations per operation. It sits upstream of the datapath consumer, which needs a registered full-width product. It accepts operands with a start/busy/done handshake. It is the control-plus-datapath stage that the step counter feeds: the counter's enable is driven by this FSM, and its terminal-count output ends the calculation.

## Interface
- WIDTH, 16, operand width in bits; power of two, at least 2; step counter width is CW = log2(WIDTH)
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset; low clears all state immediately
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  multiplicand, captured on the accepting edge
- b  input  WIDTH  multiplier, captured on the accepting edge
- busy  output  1  high while in CALC
- done  output  1  single-cycle pulse; product valid
- product  output  2*WIDTH  unsigned a*b; registered
- step  output  CW  current step-counter value (debug/observability)

## Operation
- One clock and one asynchronous active-low reset. While rst is low: state = IDLE, busy = 0, done = 0, product = 0, step = 0, operand registers = 0.
- States: IDLE, CALC, DONE.
- IDLE, when start = 1 at an edge:
  - load mcand <- a.
  - load the 2*WIDTH product register P <- {WIDTH'b0, b}.
  - clear the step counter.
  - go to CALC.
- IDLE, when start = 0: hold, with P retained.
- CALC, each edge:
  - if P[0] = 1, upper = P[2W-1:W] + mcand, formed in WIDTH+1 bits including carry; otherwise upper = P[2W-1:W] with carry 0.
  - P <- {carry, upper[W-1:0], P[W-1:1]}, a logical right shift with carry in.
  - step counter increments.
- Terminal count: on the edge where step = WIDTH-1 (counter cout = 1), the final iteration is performed and the FSM goes to DONE. The counter wraps to 0.
- DONE: done = 1 for exactly one cycle, then unconditionally IDLE.
- start is ignored in CALC and DONE; there is no queuing.
- product = P at all times.
  - Valid from the DONE cycle onward.
  - Held through IDLE until the next start is accepted.
  - Intermediate values during CALC are don't-care to consumers.
- Arithmetic is unsigned only. No overflow is possible; the 2*WIDTH result is exact.
- a and b may change freely after the accepting edge.

## Timing
- start sampled high at edge t0 (in IDLE) -> CALC from t0.
- busy is high for exactly WIDTH cycles, edges t1..tWIDTH.
- done is high in the cycle after edge tWIDTH. busy and done are never high together.
- Latency from the accepting edge to done rising is WIDTH cycles; done is high during cycle WIDTH+1. For WIDTH = 16, done is high 16 edges after the accepting edge.
- Minimum start-to-start period is WIDTH+2 cycles: start held high continuously is accepted again on the first edge in IDLE after DONE.
- Reset asserted mid-CALC: immediate abort, all outputs 0. After release, the first edge with start = 1 is accepted normally.
- Reset release is synchronised by the existing reset scheme. This block adds no synchroniser.

## Structure
- Shared package mult_pkg:
  - typedef enum of states: IDLE, CALC, DONE.
  - default WIDTH constant.
- Sub-module step_counter:
  - CW-bit up-counter with en, synchronous clr and asynchronous active-low rst.
  - cout = 1 when count is all ones.
  - The FSM drives en = (state == CALC) and clr = accept.
- Top module: FSM register, mcand register, P register and the WIDTH+1-bit adder.

## Test plan
- Reset, then a = 3, b = 5, start for one cycle:
  - busy high for 16 cycles.
  - done pulses once, 16 edges after acceptance.
  - product = 0x0000000F, held in IDLE afterward.
- a = 0xFFFF, b = 0xFFFF -> product = 0xFFFE0001 (carry-path check).
- a = 0x1234, b = 0 and a = 0, b = 0xABCD -> product = 0 in both cases; done timing unchanged.
- Pulse start again at the 5th busy cycle with different operands:
  - ignored.
  - product equals the first operation's result.
  - only one done pulse.
- Drop rst low at the 8th busy cycle:
  - busy, done, product and step go to 0 asynchronously.
  - after release, a = 7, b = 9 completes with product = 63.
- Hold start high with a = 0x0100, b = 0x0100:
  - results of 0x00010000 with done pulses exactly 18 cycles apart.
  - step wraps 15 -> 0 each operation.
